// File: rtl/rsa_decrypt.sv
// =============================================================================
// Module   : rsa_decrypt
// Purpose  : Computes m = c^d mod n by right-to-left binary exponentiation
//            with a W-cycle bit-serial modular multiplier.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module rsa_decrypt #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [W-1:0] n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] m,
  output logic         err,
  output logic         busy
);

  localparam int              C_CW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [C_CW-1:0] C_CNT_TOP = C_CW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MUL_R = 3'd2,
    S_MUL_B = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_r;
  logic [W-1:0]    r_e;
  logic [W-1:0]    r_n;
  logic [W+1:0]    r_acc;
  logic [C_CW-1:0] r_cnt;
  logic            r_err;
  logic [W-1:0]    r_m;
  logic            r_err_o;
  logic            r_out_valid;

  logic [W-1:0]    w_x;
  logic [W+1:0]    w_n2;
  logic [W+1:0]    w_sum;
  logic [W+1:0]    w_s1;
  logic [W+1:0]    w_s2;
  logic            w_last;
  logic            w_load_err;
  logic [W-1:0]    w_e_shift;

  // MUL_R computes r*b, MUL_B computes b*b; the multiplicand is always b.
  always_comb begin
    w_x        = (r_state == S_MUL_R) ? r_r : r_b;
    w_n2       = {2'b00, r_n};
    w_sum      = (r_acc << 1) + ({2'b00, r_b} & {(W+2){w_x[r_cnt]}});
    w_s1       = (w_sum >= w_n2) ? (w_sum - w_n2) : w_sum;
    w_s2       = (w_s1 >= w_n2) ? (w_s1 - w_n2) : w_s1;
    w_last     = (r_cnt == '0);
    w_load_err = (r_n == '0) || (r_b >= r_n);
    w_e_shift  = r_e >> 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = (r_state == S_IDLE);
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_load_err || (r_e == '0)) w_state_nxt = S_DONE;
        else if (r_e[0])               w_state_nxt = S_MUL_R;
        else                           w_state_nxt = S_MUL_B;
      end
      S_MUL_R: if (w_last) w_state_nxt = (w_e_shift == '0) ? S_DONE : S_MUL_B;
      // After the square the exponent shifts, so r_e[1] becomes the current bit.
      S_MUL_B: if (w_last) w_state_nxt = r_e[1] ? S_MUL_R : S_MUL_B;
      S_DONE:  if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_b         <= '0;
      r_r         <= '0;
      r_e         <= '0;
      r_n         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_m         <= '0;
      r_err_o     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_b <= c;
            r_e <= d;
            r_n <= n;
          end
        end
        S_LOAD: begin
          r_err <= w_load_err;
          r_r   <= {{(W-1){1'b0}}, (r_n != W'(1))};
          r_acc <= '0;
          r_cnt <= C_CNT_TOP;
        end
        S_MUL_R, S_MUL_B: begin
          if (w_last) begin
            r_acc <= '0;
            r_cnt <= C_CNT_TOP;
            if (r_state == S_MUL_R) begin
              r_r <= w_s2[W-1:0];
            end else begin
              r_b <= w_s2[W-1:0];
              r_e <= w_e_shift;
            end
          end else begin
            r_acc <= w_s2;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          // First DONE cycle registers the result; out_valid follows one edge later.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_m         <= r_err ? '0 : r_r;
            r_err_o     <= r_err;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign m         = r_m;
  assign err       = r_err_o;

endmodule

`default_nettype wire

// File: doc/rsa_decrypt.md
RSA_DECRYPT -- requirements
Module: rsa_decrypt

Interface
REQ-001 SHALL have parameter W, default 128, operand width in bits for ciphertext, exponent, modulus and plaintext.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request qualifier for c, d and n.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port c  input  W  ciphertext.
REQ-007 SHALL have port d  input  W  private exponent.
REQ-008 SHALL have port n  input  W  modulus (p*q).
REQ-009 SHALL have port out_valid  output  1  result is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port m  output  W  plaintext, c^d mod n.
REQ-012 SHALL have port err  output  1  request rejected; qualified by out_valid.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL accept a request on a rising edge where in_valid and in_ready are both 1, capturing c, d and n into internal registers; later input changes SHALL be ignored.
REQ-015 SHALL drive in_ready=1 only in IDLE, so a single transaction is in flight at a time.
REQ-016 SHALL use states IDLE, LOAD, MUL_R, MUL_B and DONE. Transitions:
 - IDLE->LOAD on accept.
 - LOAD->DONE on error or d==0.
 - LOAD->MUL_R if bit 0 of d is 1, else LOAD->MUL_B.
 - MUL_R->MUL_B, or MUL_R->DONE if no exponent bits above the current bit are set.
 - MUL_B->MUL_R or MUL_B (chosen by the next exponent bit).
 - DONE->IDLE on out_ready.
REQ-017 SHALL flag error in LOAD when n==0 or c>=n; on error it SHALL present m=0 and err=1.
REQ-018 SHALL use right-to-left binary exponentiation: r initialised to 1 mod n, b=c; per exponent bit, LSB first:
 - if the bit is 1, r=r*b mod n (MUL_R);
 - then b=b*b mod n (MUL_B), skipped once the remaining exponent is zero.
REQ-019 SHALL implement each modular multiply x*y mod n bit-serially over exactly W cycles, processing x from MSB to LSB; each cycle: acc=2*acc; add y if the current bit of x is 1; subtract n while acc>=n (at most two subtractions).
REQ-020 SHALL size the accumulator at W+2 bits so that no intermediate value overflows for any n<2^W.
REQ-021 SHALL make the next-bit decision in the final cycle of each multiply, so no idle cycles occur between multiplies.
REQ-022 SHALL assert out_valid exactly L cycles after the accept edge, where:
 - L=2 for error or d==0;
 - otherwise L = 2 + W*(popcount(d) + bitlen(d) - 1).
REQ-023 SHALL return m=1 for d==0 and n>1, and m=0 whenever n==1.
REQ-024 SHALL hold m, err and out_valid stable in DONE until out_ready=1; the handshake edge SHALL clear out_valid and return the block to IDLE.
REQ-025 SHALL drive m and err from registers only, with no combinational path from inputs to outputs.

Reset
REQ-026 SHALL on reset, at any time including mid-operation, immediately force the following, discarding any in-flight transaction:
 - state=IDLE, in_ready=1, out_valid=0, busy=0;
 - m=0, err=0;
 - all internal registers zero.
REQ-027 SHALL accept a new request on the first rising edge after reset deasserts.

Verification
REQ-028 SHALL cover: W=128, n=3233, d=2753, c=2790 -> m=65, err=0, out_valid exactly 2050 cycles after accept.
REQ-029 SHALL cover: d=0, n=3233, c=5 -> m=1 at L=2; then n=1, c=0, d=7 -> m=0, err=0.
REQ-030 SHALL cover: c=3233, n=3233, d=17, and separately n=0 -> each gives err=1, m=0 at L=2.
REQ-031 SHALL cover: out_ready held 0 for 10 cycles after out_valid -> m and err stable, in_ready=0, and in_valid pulses in that window not accepted.
REQ-032 SHALL cover: reset pulsed 500 cycles into the 2753-exponent case -> next edge shows out_valid=0 and in_ready=1; the request reissued after reset yields m=65.
REQ-033 SHALL cover: 1000 random W=128 requests with n odd and c<n, back-to-back with random out_ready stalls -> every m matches a reference model and every latency matches REQ-022.
